// File: rtl/fifo_burst_reader.sv
// Read-side burst master for the 8-deep FIFO: drains burst_len words and streams them on valid/ready.
// Define FIFO_RD_TIMEOUT_EN to build the S_REQ stall timeout; otherwise timeout is tied low.
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int LEN_WIDTH  = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic                  fifo_empty,
    input  logic                  fifo_rd_ack,
    input  logic                  fifo_rd_err,
    input  logic [DATA_WIDTH-1:0] fifo_d_out,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [LEN_WIDTH-1:0]  err_cnt
);

    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE} state_t;

    state_t               state;
    state_t               state_next;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 stall_expired;

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_cnt;
    logic               timeout_q;

    // Counts consecutive empty cycles in S_REQ; any other cycle restarts it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (state == S_REQ && fifo_empty) begin
            stall_cnt <= stall_cnt + 1'b1;
        end else begin
            stall_cnt <= '0;
        end
    end

    assign stall_expired = (state == S_REQ) && fifo_empty &&
                           (stall_cnt == STALL_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timeout_q <= 1'b0;
        end else if (state == S_IDLE && start) begin
            timeout_q <= 1'b0;
        end else if (stall_expired) begin
            timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    assign stall_expired = 1'b0;
    assign timeout       = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_next = (burst_len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (stall_expired) begin
                    state_next = S_DONE;
                end else if (!fifo_empty) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (fifo_rd_ack) begin
                    state_next = S_HOLD;
                end else if (fifo_rd_err) begin
                    state_next = S_REQ;
                end
            end
            S_HOLD: begin
                if (m_ready) begin
                    state_next = (remaining == LEN_WIDTH'(1)) ? S_DONE : S_REQ;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // All handshake outputs decode straight from state so reset clears them without a clock edge.
    always_comb begin
        fifo_rd_en = (state == S_REQ) && !fifo_empty;
        m_valid    = (state == S_HOLD);
        busy       = (state != S_IDLE);
        done       = (state == S_DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            remaining <= '0;
            m_data    <= '0;
            err_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        remaining <= burst_len;
                        err_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (fifo_rd_ack) begin
                        m_data <= fifo_d_out;
                    end else if (fifo_rd_err && err_cnt != '1) begin
                        err_cnt <= err_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (m_ready) begin
                        remaining <= remaining - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a small behavioural model of the 8-deep FIFO.
// Define FIFO_RD_TIMEOUT_EN for both files to exercise the stall timeout.
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  burst_len;
    logic        fifo_empty;
    logic        fifo_rd_ack = 1'b0;
    logic        fifo_rd_err = 1'b0;
    logic [31:0] fifo_d_out  = '0;
    logic        fifo_rd_en;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [3:0]  err_cnt;

    always #5 clk = ~clk;

    fifo_burst_reader #(.DATA_WIDTH(32), .LEN_WIDTH(4), .TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .burst_len(burst_len),
        .fifo_empty(fifo_empty), .fifo_rd_ack(fifo_rd_ack), .fifo_rd_err(fifo_rd_err),
        .fifo_d_out(fifo_d_out), .fifo_rd_en(fifo_rd_en), .m_valid(m_valid),
        .m_data(m_data), .m_ready(m_ready), .busy(busy), .done(done),
        .timeout(timeout), .err_cnt(err_cnt)
    );

    // FIFO model: one-cycle ack/err response; err_arm forces a single error response.
    logic [31:0] mem [8];
    logic [2:0]  rp = '0;
    logic [2:0]  wp = '0;
    logic [3:0]  cnt = '0;
    logic        wr_en = 1'b0;
    logic [31:0] wr_data = '0;
    logic        fifo_clr = 1'b0;
    logic        err_arm = 1'b0;
    logic        err_used = 1'b0;
    logic        force_err;
    logic        do_rd;
    logic        do_wr;

    assign force_err  = err_arm && !err_used;
    assign do_rd      = fifo_rd_en && (cnt != 4'd0) && !force_err;
    assign do_wr      = wr_en && (cnt != 4'd8);
    assign fifo_empty = (cnt == 4'd0);

    always @(posedge clk) begin
        fifo_rd_ack <= do_rd;
        fifo_rd_err <= fifo_rd_en && !do_rd;
        err_used    <= err_arm ? (err_used | (fifo_rd_en && force_err)) : 1'b0;
        if (do_rd) begin
            fifo_d_out <= mem[rp];
            rp         <= rp + 3'd1;
        end
        if (do_wr) begin
            mem[wp] <= wr_data;
            wp      <= wp + 3'd1;
        end
        if (fifo_clr) begin
            cnt <= '0;
            rp  <= '0;
            wp  <= '0;
        end else begin
            cnt <= cnt + {3'b0, do_wr} - {3'b0, do_rd};
        end
    end

    // Monotonic event counters; tests take snapshots and compare deltas.
    logic [31:0] got [64];
    int got_n = 0;
    int rd_pulses = 0;
    int done_pulses = 0;

    always @(posedge clk) begin
        if (fifo_rd_en) rd_pulses <= rd_pulses + 1;
        if (done) done_pulses <= done_pulses + 1;
        if (m_valid && m_ready) begin
            got[got_n % 64] <= m_data;
            got_n <= got_n + 1;
        end
    end

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    // All stimulus tasks start and end on a falling edge.
    task automatic applyStimulus(input logic [3:0] len);
        start     = 1'b1;
        burst_len = len;
        @(negedge clk);
        start     = 1'b0;
        burst_len = 4'hF;
    endtask

    task automatic fifoWrite(input logic [31:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    task automatic fifoClear();
        fifo_clr = 1'b1;
        @(negedge clk);
        fifo_clr = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int maxc);
        int n = 0;
        while (busy && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, busy}, 32'd0);
    endtask

    task automatic waitValid(input string tag, input int maxc);
        int n = 0;
        while (!m_valid && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, m_valid}, 32'd1);
    endtask

    task automatic waitWords(input string tag, input int target, input int maxc);
        int n = 0;
        while (got_n < target && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, got_n, target);
    endtask

    int gb, rb, db, n;

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        burst_len = '0;
        m_ready   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_m_valid", {31'b0, m_valid}, 32'd0);
        checkOutput("rst_busy", {31'b0, busy}, 32'd0);
        checkOutput("rst_done", {31'b0, done}, 32'd0);
        checkOutput("rst_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        checkOutput("rst_m_data", m_data, 32'd0);
        checkOutput("rst_err_cnt", {28'b0, err_cnt}, 32'd0);
        checkOutput("rst_timeout", {31'b0, timeout}, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Burst of 3 from 5 preloaded words, sink always ready.
        foreach (mem[i]) mem[i] = '0;
        fifoWrite(32'h11); fifoWrite(32'h22); fifoWrite(32'h33);
        fifoWrite(32'h44); fifoWrite(32'h55);
        m_ready = 1'b1;
        gb = got_n; rb = rd_pulses; db = done_pulses;
        applyStimulus(4'd3);
        waitIdle("b3_idle", 100);
        checkOutput("b3_words", got_n - gb, 32'd3);
        checkOutput("b3_w0", got[gb % 64], 32'h11);
        checkOutput("b3_w1", got[(gb + 1) % 64], 32'h22);
        checkOutput("b3_w2", got[(gb + 2) % 64], 32'h33);
        checkOutput("b3_rd_pulses", rd_pulses - rb, 32'd3);
        checkOutput("b3_done", done_pulses - db, 32'd1);
        checkOutput("b3_fifo_cnt", {28'b0, cnt}, 32'd2);
        checkOutput("b3_err_cnt", {28'b0, err_cnt}, 32'd0);
        fifoClear();

        // Backpressure: sink stalls for 5 cycles on the first word.
        fifoWrite(32'h11); fifoWrite(32'h22); fifoWrite(32'h33);
        fifoWrite(32'h44); fifoWrite(32'h55);
        m_ready = 1'b0;
        gb = got_n; db = done_pulses;
        applyStimulus(4'd2);
        waitValid("bp_valid", 20);
        rb = rd_pulses;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bp_hold_valid", {31'b0, m_valid}, 32'd1);
            checkOutput("bp_hold_data", m_data, 32'h11);
            @(negedge clk);
        end
        checkOutput("bp_no_rd", rd_pulses - rb, 32'd0);
        m_ready = 1'b1;
        waitIdle("bp_idle", 100);
        checkOutput("bp_w0", got[gb % 64], 32'h11);
        checkOutput("bp_w1", got[(gb + 1) % 64], 32'h22);
        checkOutput("bp_done", done_pulses - db, 32'd1);
        fifoClear();

        // Empty FIFO: stall until the writer supplies each word.
        gb = got_n; rb = rd_pulses; db = done_pulses;
        applyStimulus(4'd2);
        repeat (5) @(negedge clk);
        checkOutput("em_no_rd", rd_pulses - rb, 32'd0);
        checkOutput("em_busy", {31'b0, busy}, 32'd1);
        fifoWrite(32'hAA);
        waitWords("em_first", gb + 1, 20);
        checkOutput("em_w0", got[gb % 64], 32'hAA);
        checkOutput("em_rd_one", rd_pulses - rb, 32'd1);
        fifoWrite(32'hBB);
        waitIdle("em_idle", 20);
        checkOutput("em_w1", got[(gb + 1) % 64], 32'hBB);
        checkOutput("em_done", done_pulses - db, 32'd1);

        // One forced read error, then a successful retry.
        fifoWrite(32'h5A5A);
        err_arm = 1'b1;
        gb = got_n; rb = rd_pulses; db = done_pulses;
        applyStimulus(4'd1);
        waitIdle("er_idle", 40);
        err_arm = 1'b0;
        checkOutput("er_err_cnt", {28'b0, err_cnt}, 32'd1);
        checkOutput("er_rd_pulses", rd_pulses - rb, 32'd2);
        checkOutput("er_word", got[gb % 64], 32'h5A5A);
        checkOutput("er_done", done_pulses - db, 32'd1);

        // Zero-length burst goes straight to done; the start also clears err_cnt.
        rb = rd_pulses; db = done_pulses;
        applyStimulus(4'd0);
        checkOutput("z_done_now", {31'b0, done}, 32'd1);
        waitIdle("z_idle", 10);
        checkOutput("z_done", done_pulses - db, 32'd1);
        checkOutput("z_rd", rd_pulses - rb, 32'd0);
        checkOutput("z_err_clr", {28'b0, err_cnt}, 32'd0);

`ifdef FIFO_RD_TIMEOUT_EN
        // Empty FIFO stalls 16 cycles, then aborts with timeout.
        gb = got_n; db = done_pulses;
        applyStimulus(4'd4);
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("to_cycles", n, 32'd16);
        checkOutput("to_flag", {31'b0, timeout}, 32'd1);
        waitIdle("to_idle", 10);
        checkOutput("to_words", got_n - gb, 32'd0);
        checkOutput("to_done", done_pulses - db, 32'd1);
        fifoWrite(32'h77);
        gb = got_n;
        applyStimulus(4'd1);
        checkOutput("to_clear", {31'b0, timeout}, 32'd0);
        waitIdle("to_idle2", 20);
        checkOutput("to_word", got[gb % 64], 32'h77);
`else
        // Without the timeout, an empty FIFO stalls indefinitely.
        gb = got_n;
        applyStimulus(4'd1);
        repeat (30) @(negedge clk);
        checkOutput("st_busy", {31'b0, busy}, 32'd1);
        checkOutput("st_timeout", {31'b0, timeout}, 32'd0);
        fifoWrite(32'h77);
        waitIdle("st_idle", 20);
        checkOutput("st_word", got[gb % 64], 32'h77);
`endif

        // Reset asserted mid-S_HOLD, between clock edges.
        fifoWrite(32'hC3);
        err_arm = 1'b1;
        m_ready = 1'b0;
        db = done_pulses;
        applyStimulus(4'd1);
        waitValid("mr_valid", 40);
        checkOutput("mr_err_pre", {28'b0, err_cnt}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        checkOutput("mr_m_valid", {31'b0, m_valid}, 32'd0);
        checkOutput("mr_busy", {31'b0, busy}, 32'd0);
        checkOutput("mr_done", {31'b0, done}, 32'd0);
        checkOutput("mr_rd_en", {31'b0, fifo_rd_en}, 32'd0);
        checkOutput("mr_err_cnt", {28'b0, err_cnt}, 32'd0);
        checkOutput("mr_m_data", m_data, 32'd0);
        err_arm = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("mr_idle", {31'b0, busy}, 32'd0);
        checkOutput("mr_no_done", done_pulses - db, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
